// File: rtl/ctrl_pkg.sv
// Shared decode/branch constants and the next-PC source selection rule
// used by branch_pc_unit.
package ctrl_pkg;

    localparam logic [4:0] OP_BEQ  = 5'b10000;
    localparam logic [4:0] OP_BGT  = 5'b10001;
    localparam logic [4:0] OP_B    = 5'b10010;
    localparam logic [4:0] OP_CALL = 5'b10011;
    localparam logic [4:0] OP_RET  = 5'b10100;
    localparam logic [4:0] ALU_CMP = 5'b01101;

    typedef enum logic [1:0] {
        SEQ,
        TARGET,
        RAS,
        RA_IN
    } pc_src_e;

    // Ret outranks every branch; a call only pushes when it is not also a ret.
    function automatic pc_src_e select_src(
        input logic isret,
        input logic isubranch,
        input logic isbeq,
        input logic isbgt,
        input logic flag_e,
        input logic flag_gt,
        input logic ras_empty
    );
        if (isret)
            return ras_empty ? RA_IN : RAS;
        if (isubranch)
            return TARGET;
        if ((isbeq && flag_e) || (isbgt && flag_gt))
            return TARGET;
        return SEQ;
    endfunction

endpackage

// File: rtl/branch_pc_unit_if.sv
// Decode/execute-side signal bundle of branch_pc_unit; the decoder side is
// the master, the PC unit the slave.
interface branch_pc_unit_if #(
    parameter int ADDR_W = 32
);
    logic              valid;
    logic              stall;
    logic              iscmp;
    logic              isbeq;
    logic              isbgt;
    logic              isubranch;
    logic              iscall;
    logic              isret;
    logic              cmp_eq;
    logic              cmp_gt;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] ra_in;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] link_pc;
    logic              taken;
    logic              flag_e;
    logic              flag_gt;
    logic              ras_empty;
    logic              ras_overflow;
    logic              ras_underflow;

    modport master (
        output valid, stall, iscmp, isbeq, isbgt, isubranch, iscall, isret,
               cmp_eq, cmp_gt, branch_target, ra_in,
        input  pc, link_pc, taken, flag_e, flag_gt,
               ras_empty, ras_overflow, ras_underflow
    );

    modport slave (
        input  valid, stall, iscmp, isbeq, isbgt, isubranch, iscall, isret,
               cmp_eq, cmp_gt, branch_target, ra_in,
        output pc, link_pc, taken, flag_e, flag_gt,
               ras_empty, ras_overflow, ras_underflow
    );

endinterface

// File: rtl/branch_pc_unit_ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest
// entry and sets a sticky overflow flag; a pop when empty is ignored.
module ras_stack #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full,
    output logic              overflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr;    // next slot to write; top lives at ptr - 1
    logic [CNT_W-1:0]  count;

    assign top   = mem[ptr - PTR_W'(1)];
    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);

    // NOTE: the storage array has no reset; count alone decides validity,
    // which keeps the array a plain RAM without a reset fan-out.
    always_ff @(posedge clk) begin
        if (push)
            mem[ptr] <= push_data;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (push) begin
            ptr <= ptr + PTR_W'(1);
            if (full)
                overflow <= 1'b1;
            else
                count <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            ptr   <= ptr - PTR_W'(1);
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/branch_pc_unit.sv
// Architectural PC, compare flags and next-fetch-address priority mux,
// with a hardware return-address stack for call/ret.
module branch_pc_unit
    import ctrl_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic             clk,
    input  logic             rst,
    branch_pc_unit_if.slave  bus
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] link_pc;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] ras_top;
    logic              flag_e;
    logic              flag_gt;
    logic              taken;
    logic              ras_underflow;
    logic              ras_empty;
    logic              ras_full;
    logic              ras_overflow;
    logic              accept;
    logic              ras_push;
    logic              ras_pop;
    pc_src_e           pc_src;

    assign accept  = bus.valid && !bus.stall;
    assign link_pc = pc + ADDR_W'(4);

    assign pc_src   = select_src(bus.isret, bus.isubranch, bus.isbeq, bus.isbgt,
                                 flag_e, flag_gt, ras_empty);
    assign ras_push = accept && !bus.isret && bus.isubranch && bus.iscall;
    assign ras_pop  = accept && bus.isret && !ras_empty;

    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    always_comb begin
        next_pc = link_pc;
        case (pc_src)
            TARGET:  next_pc = bus.branch_target;
            RAS:     next_pc = ras_top;
            RA_IN:   next_pc = bus.ra_in;
            default: next_pc = link_pc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc            <= RESET_PC;
            flag_e        <= 1'b0;
            flag_gt       <= 1'b0;
            taken         <= 1'b0;
            ras_underflow <= 1'b0;
        end else if (accept) begin
            pc            <= next_pc;
            taken         <= (pc_src != SEQ);
            ras_underflow <= (pc_src == RA_IN);
            // Branches in this same cycle still see the old flags.
            if (bus.iscmp) begin
                flag_e  <= bus.cmp_eq;
                flag_gt <= bus.cmp_gt;
            end
        end else begin
            taken         <= 1'b0;
            ras_underflow <= 1'b0;
        end
    end

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (link_pc),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .overflow  (ras_overflow)
    );

    always_comb begin
        assert (!(ras_full && ras_empty));
    end

    assign bus.pc            = pc;
    assign bus.link_pc       = link_pc;
    assign bus.taken         = taken;
    assign bus.flag_e        = flag_e;
    assign bus.flag_gt       = flag_gt;
    assign bus.ras_empty     = ras_empty;
    assign bus.ras_overflow  = ras_overflow;
    assign bus.ras_underflow = ras_underflow;

endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

Program-counter and branch-resolution block that consumes the per-instruction control flags produced by the instruction decoder (isbeq, isbgt, isubranch, iscall, isret) and turns them into the next fetch address. It holds the architectural PC, the compare flags (E, GT) written by a compare instruction, and a hardware return-address stack (RAS) for call/ret. It sits between decode/execute and instruction fetch, one instruction retired per accepted cycle.

## Interface
- ADDR_W, 32, PC and target width
- RAS_DEPTH, 8, return-address stack entries (power of two, at least 2)
- RESET_PC, 0, PC value after reset
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- valid  in  1  decoded instruction present this cycle
- stall  in  1  hold all state (PC, flags, RAS) this cycle
- iscmp  in  1  instruction is a compare (ALU signal 5'b01101 with no branch flag)
- isbeq / isbgt / isubranch / iscall / isret  in  1 each  decoder control flags
- cmp_eq, cmp_gt  in  1 each  ALU compare results, sampled when iscmp
- branch_target  in  ADDR_W  PC-relative target already computed by execute
- ra_in  in  ADDR_W  register-file return address, used only on RAS underflow
- pc  out  ADDR_W  current fetch PC
- link_pc  out  ADDR_W  pc + 4, writeback value for call
- taken  out  1  registered, high for one cycle after a redirect
- flag_e, flag_gt  out  1 each  registered compare flags
- ras_empty  out  1  RAS holds no entries
- ras_overflow  out  1  sticky, set when a call overwrote the oldest entry
- ras_underflow  out  1  one-cycle pulse when a ret found the RAS empty

## Operation
- Accept condition: valid && !stall. No accept -> every register holds; taken and ras_underflow drop to 0.
- Next PC on accept (priority top to bottom):
  - isret: RAS top when non-empty, else ra_in (pulse ras_underflow); pop when non-empty.
  - isubranch (with or without iscall): branch_target; if iscall, push pc + 4.
  - isbeq && flag_e, or isbgt && flag_gt: branch_target.
  - otherwise pc + 4.
- taken is set on the next edge when the chosen source was not pc + 4.
- iscmp on accept: flag_e <= cmp_eq, flag_gt <= cmp_gt. Flags otherwise hold. Branches use the registered flags, so the compare must retire on an earlier cycle.
- iscall and isret both set: ret wins, no push.
- RAS is circular. A push when full overwrites the oldest entry, count stays RAS_DEPTH, ras_overflow sets and stays set until reset. A pop when empty leaves the pointer unchanged.
- Arithmetic is modulo 2^ADDR_W; pc + 4 wraps silently.

## Timing
- All state updates on the rising clk edge. Next PC is visible on pc one cycle after accept (latency 1).
- link_pc is combinational from pc.
- Reset, asserted asynchronously at any time including mid-call: pc = RESET_PC, flags = 0, RAS count = 0, ras_empty = 1, taken = 0, ras_overflow = 0, ras_underflow = 0.
- Release of rst is synchronous to clk. The first accept may occur on the first edge after release.

## Structure
- Shared package ctrl_pkg: opcode constants (5'b10000 beq, 5'b10001 bgt, 5'b10010 b, 5'b10011 call, 5'b10100 ret), ALU_CMP = 5'b01101, and the next-PC source enum (SEQ, TARGET, RAS, RA_IN).
- One sub-module: ras_stack (parameters ADDR_W and RAS_DEPTH). It has push, pop, top, empty, full and overflow outputs, and a circular pointer plus count.
- The top level holds the PC register, flag registers and the priority mux.

## Test plan
- Reset then 3 plain accepts -> pc 0, 4, 8, 12. taken stays 0. ras_empty = 1.
- cmp with cmp_eq = 1, then beq with target 0x40 -> pc = 0x40, taken pulses. Repeat with cmp_eq = 0 -> pc advances by 4.
- call at pc 0x10 to target 0x100, then ret -> link_pc = 0x14 during the call. After the ret, pc = 0x14 and ras_empty = 1.
- RAS_DEPTH + 1 nested calls, then RAS_DEPTH + 1 rets -> ras_overflow set. The first RAS_DEPTH rets return in LIFO order. The last ret uses ra_in and pulses ras_underflow.
- stall held 3 cycles during a bgt with flag_gt = 1 -> pc and flags frozen. The branch is taken on the first cycle after stall drops.
- rst asserted asynchronously mid-cycle after 2 pushes -> pc = RESET_PC immediately, ras_empty = 1 and flags = 0, without waiting for a clk edge.
